muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//  Iterative RV32M multiply/divide controller beside the execute-stage ALU.
//  Accepts one M-extension op from execute and runs a 32-step shift-add multiply or restoring divide.
//  Holds Stall_MD high so fetch/decode/execute freeze until the result is ready.
//  Result is muxed onto the execute result path by the instantiating stage.
// PARAMETERS
//  WIDTH   32   operand/result width; iteration count = WIDTH, counter width = $clog2(WIDTH)
// PORTS
//  CLK           in   1      clock, all state updates on rising edge
//  RST_N         in   1      synchronous active-low reset
//  MD_Start_E    in   1      valid M-extension instruction present in execute
//  MD_Op_E       in   3      md_op_t: MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU
//  MD_SrcA_E     in   WIDTH  rs1 operand (forwarded value)
//  MD_SrcB_E     in   WIDTH  rs2 operand (forwarded value)
//  Flush_E       in   1      execute-stage flush from branch/jump resolution
//  Stall_MD      out  1      hold F/D/E pipeline registers
//  MD_Done_E     out  1      single-cycle pulse; MD_Result_E valid
//  MD_Result_E   out  WIDTH  final result, held until next start
//  MD_Illegal_E  out  1      op not supported in this build (pulse with Done)
// BEHAVIOUR
//  Reset (RST_N=0 at edge): state=IDLE, counter=0, MD_Result_E=0, MD_Done_E=0, Stall_MD=0, MD_Illegal_E=0.
//  States: IDLE, MUL, DIV, DONE.
//  IDLE:
//   - MD_Start_E=1 & !Flush_E: latch |A|,|B|, result-sign flags, op; counter=WIDTH-1.
//   - Go to MUL or DIV; Stall_MD=1 combinationally in this cycle.
//  MUL/DIV:
//   - One step per cycle; Stall_MD=1.
//   - At counter==0, go to DONE; otherwise decrement the counter.
//  DONE:
//   - Stall_MD=0; MD_Done_E=1; MD_Result_E updates to the sign-corrected result.
//   - MD_Start_E is ignored here because the same instruction is still in E. Go to IDLE.
//  Latency, normal op: start cycle + WIDTH iterate cycles + DONE = WIDTH+2 (34).
//  Stall_MD is high for exactly WIDTH+1 cycles.
//  Multiply: 2*WIDTH-bit product of magnitudes.
//   - Signedness: MULH both signed, MULHSU A only, MULHU/MUL none.
//   - Negate the 64-bit product if signs differ.
//   - MUL returns low word; MULH* return high word.
//  Divide: restoring, on magnitudes.
//   - Quotient sign = sA^sB (DIV only); remainder sign = sA (REM only).
//  Special cases, detected in IDLE, skip iteration and go straight to DONE (latency 2, stall 1 cycle):
//   - Divide by zero: quotient=all-ones; remainder=dividend.
//   - Signed overflow (0x80000000 / -1): DIV=0x80000000; REM=0.
//  Flush_E in any state: next state=IDLE, no Done pulse, MD_Result_E unchanged.
//   - Flush has priority over MD_Start_E.
//  Reset mid-operation: state returns to IDLE, all outputs return to reset values, no Done.
//  MD_Op_E and operands are sampled only in IDLE; changes during MUL/DIV are ignored.
// CONFIGURATION
//  `MULDIV_DIV_EN` defined:
//   - DIV/DIVU/REM/REMU supported as above.
//   - MD_Illegal_E is tied to 0.
//  `MULDIV_DIV_EN` undefined:
//   - The DIV state and divider logic are removed.
//   - Divide ops go IDLE->DONE with MD_Result_E=0 and MD_Illegal_E=1 during DONE.
//   - Multiply is unaffected.
// STRUCTURE
//  definitions package gets:
//   - typedef enum logic[2:0] md_op_t {MD_MUL..MD_REMU}
//   - typedef enum md_state_t {MD_IDLE, MD_MUL, MD_DIV, MD_DONE}
//  One sub-module muldiv_step:
//   - Combinational single iteration (add-shift or subtract-restore) on {acc, q} registers.
//   - Instantiated once, selected by state.
// TESTING
//  1. MUL 7*-3: Stall_MD high 33 cycles, Done at cycle 34 -> Result=0xFFFFFFEB.
//  2. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU(-1,2) -> 0xFFFFFFFF.
//  3. DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2.
//  4. DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000; all with Done 2 cycles after start.
//  5. Flush_E at iteration 10 -> IDLE next cycle, no Done, Stall_MD low; new MUL 3*4 then yields 12.
//  6. RST_N low mid-DIV -> all outputs 0 next edge; without MULDIV_DIV_EN, DIVU 9/3 -> Result 0, Illegal=1.

Source files
------------

// File: rtl/muldiv_sequencer_pkg.sv
// Shared types and op-decode helpers for the RV32M multiply/divide sequencer.
package muldiv_sequencer_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_t;

    typedef enum logic [1:0] {
        MD_S_IDLE = 2'd0,
        MD_S_MUL  = 2'd1,
        MD_S_DIV  = 2'd2,
        MD_S_DONE = 2'd3
    } md_state_t;

    function automatic logic op_is_div(input md_op_t op);
        return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
    endfunction

    function automatic logic op_a_signed(input md_op_t op);
        return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    endfunction

    function automatic logic op_b_signed(input md_op_t op);
        return op inside {MD_MULH, MD_DIV, MD_REM};
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One shift-add multiply or restoring-divide iteration on the {acc, q} pair.
// The divide path is only built with `MULDIV_DIV_EN defined.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH-1:0] mul_q;

    assign mul_sum = {1'b0, acc_i} + (q_i[0] ? {1'b0, b_i} : {(WIDTH+1){1'b0}});
    assign mul_acc = mul_sum[WIDTH:1];
    assign mul_q   = {mul_sum[0], q_i[WIDTH-1:1]};

`ifdef MULDIV_DIV_EN
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic             fits;
    logic [WIDTH-1:0] div_acc;
    logic [WIDTH-1:0] div_q;

    // acc stays below b, so the shifted remainder fits WIDTH+1 bits and the
    // top bit of the difference is a clean borrow.
    assign rem_sh  = {acc_i, q_i[WIDTH-1]};
    assign diff    = rem_sh - {1'b0, b_i};
    assign fits    = ~diff[WIDTH];
    assign div_acc = fits ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign div_q   = {q_i[WIDTH-2:0], fits};

    assign acc_o = is_div_i ? div_acc : mul_acc;
    assign q_o   = is_div_i ? div_q   : mul_q;
`else
    logic unused_is_div;
    assign unused_is_div = is_div_i;

    assign acc_o = mul_acc;
    assign q_o   = mul_q;
`endif

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M iterative multiply/divide sequencer beside the execute-stage ALU.
// Build option `MULDIV_DIV_EN adds DIV/DIVU/REM/REMU; without it they complete as illegal.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// MD_S_IDLE  | waiting for an op in E; latches magnitudes and result sign
// MD_S_MUL   | one shift-add step per cycle, counter counts down to 0
// MD_S_DIV   | one restoring-divide step per cycle, counter counts down to 0
// MD_S_DONE  | Done pulse with the sign-corrected result; pipeline released
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             MD_Start_E,
    input  logic [2:0]       MD_Op_E,
    input  logic [WIDTH-1:0] MD_SrcA_E,
    input  logic [WIDTH-1:0] MD_SrcB_E,
    input  logic             Flush_E,
    output logic             Stall_MD,
    output logic             MD_Done_E,
    output logic [WIDTH-1:0] MD_Result_E,
    output logic             MD_Illegal_E
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] fin_q, fin_d;
    logic [WIDTH-1:0] result_q, result_d;
    md_op_t           op_q, op_d;
    logic             neg_q, neg_d;
    logic             illegal_q, illegal_d;

    md_op_t           op_in;
    logic             sign_a, sign_b, start_ok;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] step_acc, step_q;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] final_res;

    logic             stall;
    logic             done;
    logic             illegal_o;
    logic [WIDTH-1:0] res_o;

    assign op_in    = md_op_t'(MD_Op_E);
    assign start_ok = MD_Start_E & ~Flush_E;
    assign sign_a   = MD_SrcA_E[WIDTH-1] & op_a_signed(op_in);
    assign sign_b   = MD_SrcB_E[WIDTH-1] & op_b_signed(op_in);
    assign mag_a    = sign_a ? -MD_SrcA_E : MD_SrcA_E;
    assign mag_b    = sign_b ? -MD_SrcB_E : MD_SrcB_E;

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .is_div_i (state_q == MD_S_DIV),
        .acc_i    (acc_q),
        .q_i      (q_q),
        .b_i      (b_q),
        .acc_o    (step_acc),
        .q_o      (step_q)
    );

    assign prod = neg_q ? -{step_acc, step_q} : {step_acc, step_q};

`ifdef MULDIV_DIV_EN
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] quo, rem;
    logic             div_zero, div_ovf;
    logic [WIDTH-1:0] special_res;

    assign quo      = neg_q ? -step_q   : step_q;
    assign rem      = neg_q ? -step_acc : step_acc;
    assign div_zero = (MD_SrcB_E == '0);
    assign div_ovf  = (op_in == MD_DIV || op_in == MD_REM) &&
                      (MD_SrcA_E == SMIN) && (MD_SrcB_E == '1);

    always_comb begin
        special_res = '0;
        if (div_zero) begin
            special_res = (op_in == MD_DIV || op_in == MD_DIVU) ? '1 : MD_SrcA_E;
        end else if (op_in == MD_DIV) begin
            special_res = SMIN;
        end
    end
`endif

    always_comb begin
        final_res = prod[2*WIDTH-1:WIDTH];
        case (op_q)
            MD_MUL:          final_res = prod[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
            MD_DIV, MD_DIVU: final_res = quo;
            MD_REM, MD_REMU: final_res = rem;
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        q_d       = q_q;
        b_d       = b_q;
        fin_d     = fin_q;
        result_d  = result_q;
        op_d      = op_q;
        neg_d     = neg_q;
        illegal_d = illegal_q;
        stall     = 1'b0;
        done      = 1'b0;
        illegal_o = 1'b0;
        res_o     = result_q;

        case (state_q)
            MD_S_IDLE: begin
                if (start_ok) begin
                    stall     = 1'b1;
                    op_d      = op_in;
                    neg_d     = (op_in == MD_REM) ? sign_a : (sign_a ^ sign_b);
                    acc_d     = '0;
                    q_d       = mag_a;
                    b_d       = mag_b;
                    cnt_d     = CNT_LAST;
                    illegal_d = 1'b0;
                    if (op_is_div(op_in)) begin
`ifdef MULDIV_DIV_EN
                        if (div_zero || div_ovf) begin
                            state_d = MD_S_DONE;
                            fin_d   = special_res;
                        end else begin
                            state_d = MD_S_DIV;
                        end
`else
                        state_d   = MD_S_DONE;
                        fin_d     = '0;
                        illegal_d = 1'b1;
`endif
                    end else begin
                        state_d = MD_S_MUL;
                    end
                end
            end
`ifdef MULDIV_DIV_EN
            MD_S_MUL, MD_S_DIV: begin
`else
            MD_S_MUL: begin
`endif
                stall = 1'b1;
                acc_d = step_acc;
                q_d   = step_q;
                if (cnt_q == '0) begin
                    state_d = MD_S_DONE;
                    fin_d   = final_res;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            MD_S_DONE: begin
                // Start is still asserted by the same instruction here.
                done      = 1'b1;
                illegal_o = illegal_q;
                res_o     = fin_q;
                result_d  = fin_q;
                state_d   = MD_S_IDLE;
            end
            default: state_d = MD_S_IDLE;
        endcase

        if (Flush_E) begin
            state_d   = MD_S_IDLE;
            result_d  = result_q;
            done      = 1'b0;
            illegal_o = 1'b0;
            res_o     = result_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= MD_S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            b_q       <= '0;
            fin_q     <= '0;
            result_q  <= '0;
            op_q      <= MD_MUL;
            neg_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            b_q       <= b_d;
            fin_q     <= fin_d;
            result_q  <= result_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            illegal_q <= illegal_d;
        end
    end

    assign Stall_MD    = stall;
    assign MD_Done_E   = done;
    assign MD_Result_E = res_o;

`ifdef MULDIV_DIV_EN
    logic unused_illegal;
    assign unused_illegal = illegal_o;
    assign MD_Illegal_E   = 1'b0;
`else
    assign MD_Illegal_E   = illegal_o;
`endif

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed vector table, flush/reset sequences,
// and random ops against an arithmetic reference model.
module tb_muldiv_sequencer;

    logic        CLK = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a, src_b;
    logic        flush;
    logic        stall, done, illegal;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .CLK          (CLK),
        .RST_N        (rst_n),
        .MD_Start_E   (start),
        .MD_Op_E      (op),
        .MD_SrcA_E    (src_a),
        .MD_SrcB_E    (src_b),
        .Flush_E      (flush),
        .Stall_MD     (stall),
        .MD_Done_E    (done),
        .MD_Result_E  (result),
        .MD_Illegal_E (illegal)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ill;
        int          lat;
        string       nm;
    } vec_t;

    vec_t vec [13];

    function automatic vec_t mk(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] r, input int lat, input string nm);
        vec_t v;
        v.op = o; v.a = a; v.b = b; v.res = r; v.ill = 1'b0; v.lat = lat; v.nm = nm;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic following the RV32M rules.
    task automatic ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] r, output logic ill, output int lat);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        r = 32'b0; ill = 1'b0; lat = 34; p = 64'b0;
        case (o)
            3'd0: begin p = sa * sb; r = p[31:0];  end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            default: begin
`ifdef MULDIV_DIV_EN
                if (b == 32'b0) begin
                    lat = 2;
                    r = (o == 3'd4 || o == 3'd5) ? 32'hFFFF_FFFF : a;
                end else if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lat = 2;
                    r = (o == 3'd4) ? 32'h8000_0000 : 32'b0;
                end else begin
                    case (o)
                        3'd4:    p = sa / sb;
                        3'd5:    p = ua / ub;
                        3'd6:    p = sa % sb;
                        default: p = ua % ub;
                    endcase
                    r = p[31:0];
                end
`else
                lat = 2; ill = 1'b1; r = 32'b0;
`endif
            end
        endcase
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic ei, input int elat,
                          input bit scramble, input string nm);
        int cyc, stalls;
        bit got;
        cyc = 0; stalls = 0; got = 0;
        @(posedge CLK); #1;
        start = 1'b1; op = o; src_a = a; src_b = b;
        while (!got && cyc < 100) begin
            @(negedge CLK);
            cyc++;
            if (stall) stalls++;
            if (done) begin
                got = 1;
                check({nm, ".res"}, result, er);
                check({nm, ".ill"}, {31'b0, illegal}, {31'b0, ei});
                check({nm, ".lat"}, 32'(cyc), 32'(elat));
                check({nm, ".stall"}, 32'(stalls), 32'(elat - 1));
            end else begin
                @(posedge CLK); #1;
                if (scramble) begin
                    op = 3'($urandom_range(0, 7)); src_a = $urandom; src_b = $urandom;
                end
            end
        end
        if (!got) check({nm, ".timeout"}, 32'(cyc), 32'(elat));
        @(posedge CLK); #1;
        start = 1'b0;
        @(negedge CLK);
        check({nm, ".pulse"}, {30'b0, done, stall}, 32'b0);
        check({nm, ".hold"}, result, er);
    endtask

    task automatic expect_quiet(input string nm, input int cycles);
        int n_done, n_stall;
        n_done = 0; n_stall = 0;
        repeat (cycles) begin
            @(negedge CLK);
            if (done) n_done++;
            if (stall) n_stall++;
        end
        check({nm, ".no_done"}, 32'(n_done), 32'b0);
        check({nm, ".no_stall"}, 32'(n_stall), 32'b0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] er;
        logic        ei;
        int          el;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        vec[0]  = mk(3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "mul_7x-3");
        vec[1]  = mk(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mulhu_ff");
        vec[2]  = mk(3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 34, "mulh_ff");
        vec[3]  = mk(3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 34, "mulhsu_-1x2");
        vec[4]  = mk(3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34, "div_-7/2");
        vec[5]  = mk(3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34, "rem_-7/2");
        vec[6]  = mk(3'd5, 32'd100,        32'd7,         32'd14,        34, "divu_100/7");
        vec[7]  = mk(3'd7, 32'd100,        32'd7,         32'd2,         34, "remu_100/7");
        vec[8]  = mk(3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 2,  "div_5/0");
        vec[9]  = mk(3'd6, 32'd5,          32'd0,         32'd5,         2,  "rem_5/0");
        vec[10] = mk(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 2,  "div_ovf");
        vec[11] = mk(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 2,  "rem_ovf");
        vec[12] = mk(3'd5, 32'd9,          32'd3,         32'd3,         34, "divu_9/3");
`ifndef MULDIV_DIV_EN
        for (int i = 0; i < 13; i++) begin
            if (vec[i].op[2]) begin
                vec[i].res = 32'b0; vec[i].ill = 1'b1; vec[i].lat = 2;
            end
        end
`endif

        rst_n = 1'b0; start = 1'b0; op = 3'd0; src_a = 32'b0; src_b = 32'b0; flush = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset.stall",   {31'b0, stall},   32'b0);
        check("reset.done",    {31'b0, done},    32'b0);
        check("reset.result",  result,           32'b0);
        check("reset.illegal", {31'b0, illegal}, 32'b0);
        @(posedge CLK); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++)
            run_op(vec[i].op, vec[i].a, vec[i].b, vec[i].res, vec[i].ill, vec[i].lat, 1'b0, vec[i].nm);

        // Flush at iteration 10 of a multiply: no Done, result unchanged.
        run_op(3'd0, 32'd2, 32'd21, 32'd42, 1'b0, 34, 1'b0, "mul_2x21");
        @(posedge CLK); #1;
        start = 1'b1; op = 3'd0; src_a = 32'd5; src_b = 32'd6;
        repeat (10) begin @(posedge CLK); #1; end
        flush = 1'b1; start = 1'b0;
        @(negedge CLK);
        check("flush.stall_during", {31'b0, stall}, 32'd1);
        @(posedge CLK); #1;
        flush = 1'b0;
        @(negedge CLK);
        check("flush.stall_after",  {31'b0, stall}, 32'b0);
        check("flush.result_kept",  result, 32'd42);
        expect_quiet("flush", 40);
        run_op(3'd0, 32'd3, 32'd4, 32'd12, 1'b0, 34, 1'b0, "mul_3x4");

        // Flush wins over a simultaneous start in IDLE.
        @(posedge CLK); #1;
        start = 1'b1; flush = 1'b1; op = 3'd0; src_a = 32'd9; src_b = 32'd9;
        @(negedge CLK);
        check("flush_prio.stall", {31'b0, stall}, 32'b0);
        @(posedge CLK); #1;
        start = 1'b0; flush = 1'b0;
        expect_quiet("flush_prio", 40);
        check("flush_prio.result", result, 32'd12);

        // Synchronous reset in the middle of an iteration.
        @(posedge CLK); #1;
`ifdef MULDIV_DIV_EN
        start = 1'b1; op = 3'd5; src_a = 32'd1000; src_b = 32'd3;
`else
        start = 1'b1; op = 3'd3; src_a = 32'd1000; src_b = 32'd3;
`endif
        repeat (6) begin @(posedge CLK); #1; end
        rst_n = 1'b0; start = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check("midrst.stall",   {31'b0, stall},   32'b0);
        check("midrst.done",    {31'b0, done},    32'b0);
        check("midrst.result",  result,           32'b0);
        check("midrst.illegal", {31'b0, illegal}, 32'b0);
        @(posedge CLK); #1;
        rst_n = 1'b1;
        expect_quiet("midrst", 40);

        for (int i = 0; i < 150; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra = pick();
            rb = pick();
            ref_model(rop, ra, rb, er, ei, el);
            run_op(rop, ra, rb, er, ei, el, 1'($urandom_range(0, 1)), $sformatf("rnd%0d_op%0d", i, rop));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
